axi4_lite_slave_regs: RTL and testbench

AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

---
 rtl/axi4_lite_pkg.sv | 23 ++
 rtl/axi4_lite_slv_regfile.sv | 37 +++
 rtl/axi4_lite_slave_regs.sv | 196 +++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes and FSM states.
package axi4_lite_pkg;

   localparam int unsigned STRB_W = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WAIT_DATA,
      WR_WAIT_ADDR,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_e;

endpackage

// File: rtl/axi4_lite_slv_regfile.sv
// Register storage: byte-strobed synchronous write port, asynchronous read port.
module axi4_lite_slv_regfile
   import axi4_lite_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [$clog2(NUM_REGS)-1:0] widx,
   input  logic [DATA_WIDTH-1:0]       wdata,
   input  logic [STRB_W-1:0]           wstrb,
   input  logic [$clog2(NUM_REGS)-1:0] ridx,
   output logic [DATA_WIDTH-1:0]       rd_data_c
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wstrb[i]) mem_d[widx][8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
   end

   assign rd_data_c = mem_q[ridx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with independent read/write FSMs.
// Define AXI4_LITE_SLV_ERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_slave_regs
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_W-1:0]     wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] RANGE_END = ADDR_WIDTH'(NUM_REGS * 4);
`ifdef AXI4_LITE_SLV_ERR_EN
   localparam resp_e ERR_RESP = RESP_SLVERR;
`else
   localparam resp_e ERR_RESP = RESP_OKAY;
`endif

   wr_state_e             wr_state_q, wr_state_d;
   rd_state_e             rd_state_q, rd_state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   resp_e                 bresp_q, bresp_d;
   resp_e                 rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]     c_strb;
   logic                  c_in_range, ar_in_range;
   logic [DATA_WIDTH-1:0] reg_rdata;

   assign aw_hs = awvalid && awready_q;
   assign w_hs  = wvalid && wready_q;
   assign ar_hs = arvalid && arready_q;

   assign c_in_range  = (c_addr < RANGE_END);
   assign ar_in_range = (araddr < RANGE_END);

   axi4_lite_slv_regfile #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (commit && c_in_range),
      .widx      (c_addr[IDX_W+1:2]),
      .wdata     (c_data),
      .wstrb     (c_strb),
      .ridx      (araddr[IDX_W+1:2]),
      .rd_data_c (reg_rdata)
   );

   // Write FSM: commit happens on whichever edge completes the second of AW/W.
   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      commit     = 1'b0;
      c_addr     = awaddr;
      c_data     = wdata;
      c_strb     = wstrb;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs && w_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end else if (aw_hs) begin
               awaddr_d   = awaddr;
               wr_state_d = WR_WAIT_DATA;
            end else if (w_hs) begin
               wdata_d    = wdata;
               wstrb_d    = wstrb;
               wr_state_d = WR_WAIT_ADDR;
            end
         end
         WR_WAIT_DATA: begin
            c_addr = awaddr_q;
            if (w_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_WAIT_ADDR: begin
            c_data = wdata_q;
            c_strb = wstrb_q;
            if (aw_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bready) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
      if (commit) bresp_d = c_in_range ? RESP_OKAY : ERR_RESP;
      awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_ADDR);
      wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_DATA);
      bvalid_d  = (wr_state_d == WR_RESP);
   end

   // Read FSM: data captured on the AR edge so a same-edge write is not visible.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs) begin
               rdata_d    = ar_in_range ? reg_rdata : '0;
               rresp_d    = ar_in_range ? RESP_OKAY : ERR_RESP;
               rd_state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (rready) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
      arready_d = (rd_state_d == RD_IDLE);
      rvalid_d  = (rd_state_d == RD_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;
   assign arready = arready_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed cases plus randomized traffic
// against an array-based register model. Honours AXI4_LITE_SLV_ERR_EN for expected responses.
module tb_axi4_lite_slave_regs;

   localparam int unsigned NREGS = 16;

   logic        clk;
   logic        rst;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_cmp = 0;
   int n_mis = 0;
   logic [31:0] model [NREGS];

   axi4_lite_slave_regs #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (NREGS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] addr);
      if (addr < 32'(NREGS * 4)) return 2'b00;
`ifdef AXI4_LITE_SLV_ERR_EN
      return 2'b10;
`else
      return 2'b00;
`endif
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
      if (addr < 32'(NREGS * 4)) return model[addr / 4];
      return 32'h0;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      if (addr < 32'(NREGS * 4)) begin
         for (int i = 0; i < 4; i++)
            if (strb[i]) model[addr / 4][8*i +: 8] = data[8*i +: 8];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive AW and W with independent start delays, then hold bready low for b_dly cycles.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done, w_done, a_hs, d_hs;
      int c;
      aw_done = 0; w_done = 0; c = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && c < 64) begin
         if (!aw_done && c >= aw_dly) awvalid = 1'b1;
         if (!w_done && c >= w_dly)   wvalid  = 1'b1;
         a_hs = awvalid && awready;
         d_hs = wvalid && wready;
         tick();
         if (a_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (d_hs) begin w_done = 1; wvalid = 1'b0; end
         c++;
      end
      chk("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
      model_write(addr, data, strb);
      chk("bvalid_after_commit", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'(exp_resp(addr)));
      for (int i = 0; i < b_dly; i++) begin
         tick();
         chk("bvalid_hold", 32'(bvalid), 32'd1);
         chk("bresp_hold", 32'(bresp), 32'(exp_resp(addr)));
         chk("awready_in_resp", 32'(awready), 32'd0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_cleared", 32'(bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly);
      logic [31:0] ed;
      logic [1:0]  er;
      bit done;
      int c;
      ed = exp_rdata(addr); er = exp_resp(addr);
      done = 0; c = 0;
      araddr = addr; arvalid = 1'b1;
      while (!done && c < 64) begin
         done = arready;
         tick();
         c++;
      end
      arvalid = 1'b0;
      chk("rd_handshake_done", 32'(done), 32'd1);
      chk("rvalid_latency", 32'(rvalid), 32'd1);
      chk("rdata", rdata, ed);
      chk("rresp", 32'(rresp), 32'(er));
      for (int i = 0; i < r_dly; i++) begin
         tick();
         chk("rvalid_hold", 32'(rvalid), 32'd1);
         chk("rdata_hold", rdata, ed);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rvalid_cleared", 32'(rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      rst = 1'b1;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0;
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;

      // Reset values
      repeat (2) tick();
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_awready", 32'(awready), 32'd1);
      chk("idle_wready", 32'(wready), 32'd1);
      chk("idle_arready", 32'(arready), 32'd1);

      // AW+W together then read back
      do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(32'h04, 0);
      chk("reg1_deadbeef", exp_rdata(32'h04), 32'hDEADBEEF);

      // W first, AW three cycles later, partial strobe
      do_write(32'h08, 32'h11223344, 4'h5, 3, 0, 0);
      do_read(32'h08, 1);
      chk("reg2_strobed", model[2], 32'h00220044);

      // Out-of-range write and read
      do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1);
      do_read(32'h40, 0);
      for (int i = 0; i < int'(NREGS); i++) do_read(32'(i * 4), 0);

      // bvalid backpressure with a second write offered meanwhile
      awaddr = 32'h0C; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick();
      model_write(32'h0C, 32'h01020304, 4'hF);
      awaddr = 32'h0C; wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid", 32'(bvalid), 32'd1);
         chk("bp_awready", 32'(awready), 32'd0);
         chk("bp_wready", 32'(wready), 32'd0);
         tick();
      end
      awvalid = 0; wvalid = 0; bready = 1;
      tick();
      bready = 0;
      chk("bp_released", 32'(bvalid), 32'd0);
      do_read(32'h0C, 0);

      // AR and write commit on the same edge return the old value
      do_write(32'h04, 32'h55, 4'hF, 0, 0, 0);
      wdata = 32'hAA; wstrb = 4'hF; wvalid = 1;
      tick();
      wvalid = 0;
      chk("wait_addr_awready", 32'(awready), 32'd1);
      chk("wait_addr_wready", 32'(wready), 32'd0);
      awaddr = 32'h04; awvalid = 1; araddr = 32'h04; arvalid = 1;
      tick();
      awvalid = 0; arvalid = 0;
      chk("race_rvalid", 32'(rvalid), 32'd1);
      chk("race_rdata_old", rdata, 32'h55);
      chk("race_bvalid", 32'(bvalid), 32'd1);
      model_write(32'h04, 32'hAA, 4'hF);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      do_read(32'h04, 0);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 7) == 0) a = 32'h40 + 32'($urandom_range(0, 31));
         else a = 32'($urandom_range(0, 63));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0)
            do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
         else
            do_read(a, int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < int'(NREGS); i++) do_read(32'(i * 4), 0);

      // Reset while waiting for write data
      awaddr = 32'h08; awvalid = 1;
      tick();
      awvalid = 0;
      chk("wait_data_awready", 32'(awready), 32'd0);
      chk("wait_data_wready", 32'(wready), 32'd1);
      rst = 1'b1;
      #2;
      chk("midrst_awready", 32'(awready), 32'd0);
      chk("midrst_wready", 32'(wready), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
      tick();
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_wready", 32'(wready), 32'd1);
      chk("post_rst_arready", 32'(arready), 32'd1);
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
      for (int i = 0; i < int'(NREGS); i++) do_read(32'(i * 4), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
